// File: rtl/mc_sfifo_if.sv
// mc_sfifo_if: request/response bundle for mc_sfifo; master drives requests and thresholds, slave returns data and flags.
interface mc_sfifo_if #(
  parameter int Width    = 8,
  parameter int Depth    = 16,
  parameter int Channels = 4
);
  localparam int AW  = $clog2(Depth);
  localparam int ChW = Channels > 1 ? $clog2(Channels) : 1;
  logic                       WRreq;
  logic [ChW-1:0]             WRch;
  logic [Width-1:0]           WRdata;
  logic                       RDreq;
  logic [ChW-1:0]             RDch;
  logic [Width-1:0]           RDdata;
  logic                       RDvalid;
  logic [Channels-1:0]        FIFOfull;
  logic [Channels-1:0]        FIFOempty;
  logic [Channels*(AW+1)-1:0] Level;
  logic [Channels-1:0]        Overflow;
  logic [Channels-1:0]        Underflow;
  logic [AW:0]                AFthresh;
  logic [AW:0]                AEthresh;
  logic [Channels-1:0]        FIFOalmostFull;
  logic [Channels-1:0]        FIFOalmostEmpty;
  modport master (
    output WRreq, WRch, WRdata, RDreq, RDch, AFthresh, AEthresh,
    input  RDdata, RDvalid, FIFOfull, FIFOempty, Level, Overflow, Underflow,
           FIFOalmostFull, FIFOalmostEmpty
  );
  modport slave (
    input  WRreq, WRch, WRdata, RDreq, RDch, AFthresh, AEthresh,
    output RDdata, RDvalid, FIFOfull, FIFOempty, Level, Overflow, Underflow,
           FIFOalmostFull, FIFOalmostEmpty
  );
endinterface

// File: rtl/mc_sfifo.sv
// mc_sfifo: multi-channel single-clock FIFO over one shared memory, registered per-channel flags.
// Define MC_SFIFO_WATERMARK_EN to enable the almost-full/almost-empty flags.
module mc_sfifo #(
  parameter int Width    = 8,
  parameter int Depth    = 16,
  parameter int Channels = 4
) (
  input logic       clk,
  input logic       reset,
  mc_sfifo_if.slave bus
);
  localparam int AW  = $clog2(Depth);
  localparam int PW  = AW + 1;
  localparam int ChW = Channels > 1 ? $clog2(Channels) : 1;
  logic [Width-1:0]      r_mem [Channels*Depth];
  logic [PW-1:0]         r_wp [Channels];
  logic [PW-1:0]         r_rp [Channels];
  logic [PW-1:0]         w_wp_n [Channels];
  logic [PW-1:0]         w_rp_n [Channels];
  logic [PW-1:0]         w_lvl_n [Channels];
  logic [Channels*PW-1:0] r_lvl;
  logic [Channels-1:0]   r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [Channels-1:0]   w_full_n, w_empty_n, w_af_n, w_ae_n;
  logic                  w_wr_in, w_rd_in, w_wr_ok, w_rd_ok;
  logic [ChW+AW-1:0]     w_wa, w_ra;
  logic [Width-1:0]      r_rddata;
  logic                  r_rdvalid;
  assign w_wr_in = bus.WRreq && 32'(bus.WRch) < Channels;
  assign w_rd_in = bus.RDreq && 32'(bus.RDch) < Channels;
  assign w_wr_ok = reset && w_wr_in && !r_full[bus.WRch];
  assign w_rd_ok = reset && w_rd_in && !r_empty[bus.RDch];
  assign w_wa    = {bus.WRch, r_wp[bus.WRch][AW-1:0]};
  assign w_ra    = {bus.RDch, r_rp[bus.RDch][AW-1:0]};
  // next-state pointers fold in reset so flags come out of reset consistent with Level = 0
  always_comb begin
    for (int c = 0; c < Channels; c++) begin
      w_wp_n[c]    = reset ? r_wp[c] + PW'(w_wr_ok && 32'(bus.WRch) == c) : '0;
      w_rp_n[c]    = reset ? r_rp[c] + PW'(w_rd_ok && 32'(bus.RDch) == c) : '0;
      w_lvl_n[c]   = w_wp_n[c] - w_rp_n[c];
      w_full_n[c]  = w_wp_n[c][AW] != w_rp_n[c][AW] && w_wp_n[c][AW-1:0] == w_rp_n[c][AW-1:0];
      w_empty_n[c] = w_wp_n[c] == w_rp_n[c];
`ifdef MC_SFIFO_WATERMARK_EN
      w_af_n[c]    = w_lvl_n[c] >= bus.AFthresh;
      w_ae_n[c]    = w_lvl_n[c] <= bus.AEthresh;
`else
      w_af_n[c]    = 1'b0;
      w_ae_n[c]    = 1'b0;
`endif
    end
  end
`ifndef MC_SFIFO_WATERMARK_EN
  logic w_unused;
  assign w_unused = ^{bus.AFthresh, bus.AEthresh};
`endif
  always_ff @(posedge clk)
    if (w_wr_ok) r_mem[w_wa] <= bus.WRdata;
  always_ff @(posedge clk) begin
    for (int c = 0; c < Channels; c++) begin
      r_wp[c]             <= w_wp_n[c];
      r_rp[c]             <= w_rp_n[c];
      r_lvl[c*PW +: PW]   <= w_lvl_n[c];
    end
    r_full    <= w_full_n;
    r_empty   <= w_empty_n;
    r_af      <= w_af_n;
    r_ae      <= w_ae_n;
    r_rdvalid <= w_rd_ok;
    if (!reset) begin
      r_ovf    <= '0;
      r_udf    <= '0;
      r_rddata <= '0;
    end else begin
      r_ovf <= r_ovf | (w_wr_in && r_full[bus.WRch] ? Channels'(1) << bus.WRch : '0);
      r_udf <= r_udf | (w_rd_in && r_empty[bus.RDch] ? Channels'(1) << bus.RDch : '0);
      if (w_rd_ok) r_rddata <= r_mem[w_ra];
    end
  end
  assign bus.RDdata          = r_rddata;
  assign bus.RDvalid         = r_rdvalid;
  assign bus.FIFOfull        = r_full;
  assign bus.FIFOempty       = r_empty;
  assign bus.Level           = r_lvl;
  assign bus.Overflow        = r_ovf;
  assign bus.Underflow       = r_udf;
  assign bus.FIFOalmostFull  = r_af;
  assign bus.FIFOalmostEmpty = r_ae;
endmodule

// File: tb/tb_mc_sfifo.sv
// tb_mc_sfifo: randomized scoreboard bench for mc_sfifo against per-channel queue model.
module tb_mc_sfifo;
  localparam int W = 8, D = 4, C = 2, PW = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mc_sfifo_if #(.Width(W), .Depth(D), .Channels(C)) bus ();
  mc_sfifo #(.Width(W), .Depth(D), .Channels(C)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [W-1:0] mq [C][$];
  logic [W-1:0] exp_q [$];
  logic [C-1:0] m_ovf = '0, m_udf = '0, m_af = '0, m_ae = '0;
  logic [W-1:0] last_rd = '0;
  int nx_af = 3, nx_ae = 1;
  int cmp = 0, err = 0;
  bit armed = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_flags();
    logic [C-1:0] f, e;
    logic [C*PW-1:0] lv;
    for (int c = 0; c < C; c++) begin
      f[c] = mq[c].size() == D;
      e[c] = mq[c].size() == 0;
      lv[c*PW +: PW] = PW'(mq[c].size());
    end
    chk("full", 32'(bus.FIFOfull), 32'(f));
    chk("empty", 32'(bus.FIFOempty), 32'(e));
    chk("level", 32'(bus.Level), 32'(lv));
    chk("overflow", 32'(bus.Overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.Underflow), 32'(m_udf));
    chk("almost_full", 32'(bus.FIFOalmostFull), 32'(m_af));
    chk("almost_empty", 32'(bus.FIFOalmostEmpty), 32'(m_ae));
  endtask

  task automatic step(input bit wr, input int wch, input logic [W-1:0] wd,
                      input bit rd, input int rch, input bit rst = 1'b1);
    bit wa, ra;
    @(negedge clk);
    if (armed) check_flags();
    reset = rst;
    bus.WRreq = wr; bus.WRch = wch[0]; bus.WRdata = wd;
    bus.RDreq = rd; bus.RDch = rch[0];
    bus.AFthresh = 3'(nx_af); bus.AEthresh = 3'(nx_ae);
    if (!rst) begin
      for (int c = 0; c < C; c++) mq[c].delete();
      m_ovf = '0; m_udf = '0; last_rd = '0;
    end else begin
      wa = wr && mq[wch].size() < D;
      ra = rd && mq[rch].size() > 0;
      if (wr && !wa) m_ovf[wch] = 1'b1;
      if (rd && !ra) m_udf[rch] = 1'b1;
      if (ra) exp_q.push_back(mq[rch].pop_front());
      if (wa) mq[wch].push_back(wd);
    end
    for (int c = 0; c < C; c++) begin
`ifdef MC_SFIFO_WATERMARK_EN
      m_af[c] = mq[c].size() >= nx_af;
      m_ae[c] = mq[c].size() <= nx_ae;
`else
      m_af[c] = 1'b0;
      m_ae[c] = 1'b0;
`endif
    end
    if (!rst) armed = 1;
  endtask

  // monitor: pops an expected word whenever the DUT presents RDvalid
  always begin
    @(posedge clk);
    #1;
    if (bus.RDvalid === 1'b1) begin
      if (exp_q.size() == 0) chk("rdvalid_unexpected", 32'(1), 32'(0));
      else begin
        last_rd = exp_q.pop_front();
        chk("rddata", 32'(bus.RDdata), 32'(last_rd));
      end
    end else if (armed) begin
      chk("rdvalid", 32'(bus.RDvalid), 32'(0));
      chk("rdhold", 32'(bus.RDdata), 32'(last_rd));
    end
  end

  initial begin
    bus.WRreq = 0; bus.WRch = '0; bus.WRdata = '0;
    bus.RDreq = 0; bus.RDch = '0; bus.AFthresh = 3'd3; bus.AEthresh = 3'd1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, W'(8'h11 * i), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(1, 0, 8'hA0, 0, 0);
    step(1, 1, 8'hB0, 0, 0);
    step(1, 0, 8'hA1, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, W'(8'hC0 + i), 0, 0);
    step(1, 1, 8'hEE, 1, 1);
    step(1, 0, 8'hD0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, W'(8'h60 + i), 0, 0);
      step(1, 0, W'(8'h80 + i), 1, 0);
      step(0, 0, 0, 1, 0);
    end
    step(1, 0, 8'h99, 0, 0);
    step(1, 0, 8'h9A, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 97 == 0) begin
        nx_af = $urandom_range(0, 4);
        nx_ae = $urandom_range(0, 5);
      end
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1), W'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1),
           $urandom_range(0, 249) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    chk("drain", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
